ri_co_tuner_mc: RTL

Multi-channel real-to-complex tuner: one real input stream is mixed down into `CH` independent complex channels, each with its own phase accumulator, tuning word and direction. A single pipelined CORDIC rotator is time-multiplexed across channels, so the NCO and mixer are merged into one datapath. The block sits after the ADC front end and feeds per-channel decimation chains, selected by `out_ch`.

---
 rtl/ri_co_tuner_mc.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ri_co_tuner_mc.sv
// Multi-channel real-to-complex tuner: one time-multiplexed pipelined CORDIC mixes a real stream into CH channels.
// Optional build macro RI_CO_TUNER_DITHER_EN adds LFSR dither below the truncated angle bits.
//
// state    | meaning
// ST_INIT  | just out of reset, not yet accepting
// ST_IDLE  | in_ready high, waiting for a sample
// ST_ISSUE | issuing channels 1..CH-1 of the latched sample
module ri_co_tuner_mc #(
   parameter int DSZ  = 16,
   parameter int FSZ  = 32,
   parameter int CH   = 4,
   parameter int ITER = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic signed [DSZ-1:0] in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  cfg_we,
   input  logic [3:0]            cfg_ch,
   input  logic [FSZ-1:0]        cfg_freq,
   input  logic                  cfg_dir,
   input  logic                  cfg_phase_rst,
   output logic signed [DSZ-1:0] out_i,
   output logic signed [DSZ-1:0] out_q,
   output logic [3:0]            out_ch,
   output logic                  out_valid
);

   localparam int AW = DSZ + 2;
   localparam int W  = DSZ + 2;
   localparam int PS = 14;
   localparam logic signed [15:0] KINV = 16'sd19898;
   localparam logic signed [W:0]  ONE  = (W+1)'(1);
   localparam logic signed [W:0]  MAXV = (W+1)'((1 << (DSZ-1)) - 1);
   localparam logic signed [W:0]  MINV = -MAXV - ONE;

   typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ISSUE} state_t;

   state_t                state_q, state_d;
   logic [3:0]            rem_q, rem_d;
   logic signed [DSZ-1:0] smp_q, iss_smp;
   logic                  accept, iss;
   logic [3:0]            iss_ch;

   assign accept = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      iss     = 1'b0;
      iss_ch  = 4'd0;
      iss_smp = smp_q;
      case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: begin
            if (accept) begin
               iss     = 1'b1;
               iss_smp = in;
               rem_d   = 4'(CH - 1);
               if (CH > 1) state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            iss    = 1'b1;
            iss_ch = 4'(CH) - rem_q;
            rem_d  = rem_q - 4'd1;
            if (rem_q == 4'd1) state_d = ST_IDLE;
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_INIT;
         rem_q    <= 4'd0;
         in_ready <= 1'b0;
         smp_q    <= '0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         in_ready <= (state_d == ST_IDLE);
         if (accept) smp_q <= in;
      end
   end

   // Channel registers: a phase reset on the same edge beats the issue increment.
   logic [FSZ-1:0] freq_q [CH];
   logic [FSZ-1:0] acc_q  [CH];
   logic [CH-1:0]  dir_q;
   logic           cfg_hit;

   assign cfg_hit = cfg_we && ({1'b0, cfg_ch} < 5'(CH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dir_q <= '0;
         for (int c = 0; c < CH; c++) begin
            freq_q[c] <= '0;
            acc_q[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (cfg_hit && cfg_ch == 4'(c)) begin
               freq_q[c] <= cfg_freq;
               dir_q[c]  <= cfg_dir;
            end
            if (cfg_hit && cfg_ch == 4'(c) && cfg_phase_rst)
               acc_q[c] <= '0;
            else if (iss && iss_ch == 4'(c))
               acc_q[c] <= acc_q[c] + freq_q[c];
         end
      end
   end

   logic [FSZ-1:0] sel_acc, ang_full;
   logic           sel_dir;
   logic [AW-1:0]  iss_ang;

   always_comb begin
      sel_acc = '0;
      sel_dir = 1'b0;
      for (int c = 0; c < CH; c++) begin
         if (iss_ch == 4'(c)) begin
            sel_acc = acc_q[c];
            sel_dir = dir_q[c];
         end
      end
   end

   assign ang_full = sel_dir ? -sel_acc : sel_acc;

`ifdef RI_CO_TUNER_DITHER_EN
   logic [15:0]    lfsr_q;
   logic [FSZ-1:0] dith, ang_dith;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lfsr_q <= 16'hACE1;
      else if (iss)
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign dith     = FSZ'(lfsr_q) & ((FSZ'(1) << (FSZ - AW)) - FSZ'(1));
   assign ang_dith = ang_full + dith;
   assign iss_ang  = AW'(ang_dith >> (FSZ - AW));
`else
   assign iss_ang  = AW'(ang_full >> (FSZ - AW));
`endif

   // Arctangent table in units of 2*pi/2^18, rescaled to the actual angle width.
   function automatic logic signed [W-1:0] atan_lut(input int k);
      int t;
      case (k)
         0: t = 32768;  1: t = 19344;  2: t = 10221;  3: t = 5188;
         4: t = 2604;   5: t = 1303;   6: t = 652;    7: t = 326;
         8: t = 163;    9: t = 81;     10: t = 41;    11: t = 20;
         12: t = 10;    13: t = 5;     14: t = 3;     15: t = 1;
         default: t = 0;
      endcase
      if (AW >= 18) return W'(t <<< (AW - 18));
      else          return W'(t >>> (18 - AW));
   endfunction

   // Rounded arithmetic shift keeps the stage truncation error unbiased.
   function automatic logic signed [W-1:0] rsh(input logic signed [W-1:0] v, input int s);
      logic signed [W:0] t;
      if (s == 0) return v;
      t = (W+1)'(v) + (ONE <<< (s - 1));
      return W'(t >>> s);
   endfunction

   function automatic logic signed [DSZ-1:0] sat_rnd(input logic signed [W-1:0] v);
      logic signed [W:0] a, r;
      a = (W+1)'(v);
      if (v[W-1]) r = -((-a + ONE) >>> 1);
      else        r = (a + ONE) >>> 1;
      if (r > MAXV)      return DSZ'(MAXV);
      else if (r < MINV) return DSZ'(MINV);
      else               return DSZ'(r);
   endfunction

   logic                  p0_v, p1_v;
   logic [3:0]            p0_ch, p1_ch;
   logic signed [DSZ-1:0] p0_smp;
   logic [AW-1:0]         p0_ang, p1_ang;
   logic signed [W-1:0]   p1_x;
   logic signed [DSZ+15:0] prod;

   logic signed [W-1:0] xs [ITER+1];
   logic signed [W-1:0] ys [ITER+1];
   logic signed [W-1:0] zs [ITER+1];
   logic [3:0]          cs [ITER+1];
   logic [ITER:0]       vs;

   // Internal x/y carry one fractional bit; the prescale folds in 1/K.
   assign prod = p0_smp * KINV;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p0_v   <= 1'b0;
         p0_ch  <= 4'd0;
         p0_smp <= '0;
         p0_ang <= '0;
         p1_v   <= 1'b0;
         p1_ch  <= 4'd0;
         p1_x   <= '0;
         p1_ang <= '0;
         vs     <= '0;
         for (int k = 0; k <= ITER; k++) begin
            xs[k] <= '0;
            ys[k] <= '0;
            zs[k] <= '0;
            cs[k] <= 4'd0;
         end
      end else begin
         p0_v   <= iss;
         p0_ch  <= iss_ch;
         p0_smp <= iss_smp;
         p0_ang <= iss_ang;
         p1_v   <= p0_v;
         p1_ch  <= p0_ch;
         p1_x   <= W'(prod >>> PS);
         p1_ang <= p0_ang;
         vs[0]  <= p1_v;
         cs[0]  <= p1_ch;
         zs[0]  <= $signed({2'b00, p1_ang[AW-3:0]});
         case (p1_ang[AW-1 -: 2])
            2'd0: begin xs[0] <= p1_x;  ys[0] <= '0;    end
            2'd1: begin xs[0] <= '0;    ys[0] <= p1_x;  end
            2'd2: begin xs[0] <= -p1_x; ys[0] <= '0;    end
            default: begin xs[0] <= '0; ys[0] <= -p1_x; end
         endcase
         for (int k = 0; k < ITER; k++) begin
            vs[k+1] <= vs[k];
            cs[k+1] <= cs[k];
            if (!zs[k][W-1]) begin
               xs[k+1] <= xs[k] - rsh(ys[k], k);
               ys[k+1] <= ys[k] + rsh(xs[k], k);
               zs[k+1] <= zs[k] - atan_lut(k);
            end else begin
               xs[k+1] <= xs[k] + rsh(ys[k], k);
               ys[k+1] <= ys[k] - rsh(xs[k], k);
               zs[k+1] <= zs[k] + atan_lut(k);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_i     <= '0;
         out_q     <= '0;
         out_ch    <= 4'd0;
      end else begin
         out_valid <= vs[ITER];
         if (vs[ITER]) begin
            out_i  <= sat_rnd(xs[ITER]);
            out_q  <= sat_rnd(ys[ITER]);
            out_ch <= cs[ITER];
         end
      end
   end

endmodule
